code_flasher: RTL and testbench



---
 rtl/code_flasher_pkg.sv | 37 +++
 rtl/code_flasher_seg7_hex.sv | 17 +
 rtl/code_flasher.sv | 108 ++++++++++
 tb/tb_code_flasher.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/code_flasher_pkg.sv
// Shared types and segment patterns for the code flasher and its 7-segment encoder.
package code_flasher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; letters b and d are lowercase so they stay distinct from 8 and 0.
    function automatic logic [6:0] seg_pattern(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/code_flasher_seg7_hex.sv
// Combinational hex digit to active-low 7-segment encoder; blanks the display when not enabled.
module seg7_hex
    import code_flasher_pkg::*;
(
    input  logic [3:0] value,
    input  logic       enable,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (enable) begin
            seg = seg_pattern(value);
        end
    end

endmodule

// File: rtl/code_flasher.sv
// Shows a stored hex code on one 7-segment display, one digit at a time,
// most-significant digit first, with optional blank gaps between digits.
module code_flasher
    import code_flasher_pkg::*;
#(
    parameter int          NUM_DIGITS   = 2,
    parameter logic [31:0] CODE         = 32'h0000_0028,
    parameter int          DWELL_CYCLES = 4,
    parameter int          GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       digit_valid,
    output logic [3:0] digit,
    output logic [2:0] digit_idx,
    output logic [6:0] hex_out
);

    // Counters hold 0..N-1, so $clog2(N) bits suffice; keep at least one bit for N<=1.
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [DW-1:0]  DWELL_LAST  = DW'(DWELL_CYCLES - 1);
    localparam logic [GW-1:0]  GAP_LAST    = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [2:0]     FIRST_IDX   = 3'(NUM_DIGITS - 1);
    localparam logic [7:0][3:0] CODE_DIGITS = CODE;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n;
    logic [DW-1:0] dwell_cnt, dwell_n;
    logic [GW-1:0] gap_cnt, gap_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            dwell_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            dwell_cnt <= dwell_n;
            gap_cnt   <= gap_n;
        end
    end

    // Counters default to zero so they restart on every state change or digit advance.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        dwell_n = '0;
        gap_n   = '0;
        case (state)
            IDLE: begin
                idx_n = '0;
                if (start) begin
                    state_n = SHOW;
                    idx_n   = FIRST_IDX;
                end
            end
            SHOW: begin
                if (dwell_cnt == DWELL_LAST) begin
                    if (idx == 3'd0) begin
                        state_n = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                    end else begin
                        idx_n = idx - 3'd1;
                    end
                end else begin
                    dwell_n = dwell_cnt + DW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = SHOW;
                    idx_n   = idx - 3'd1;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

    assign busy        = (state == SHOW) || (state == GAP);
    assign done        = (state == DONE);
    assign digit_valid = (state == SHOW);
    assign digit       = digit_valid ? CODE_DIGITS[idx] : 4'd0;
    assign digit_idx   = idx;

    seg7_hex u_seg7_hex (
        .value  (digit),
        .enable (digit_valid),
        .seg    (hex_out)
    );

endmodule

// File: tb/tb_code_flasher.sv
// Scoreboard bench for code_flasher: three parameterisations, expected per-cycle outputs queued at start.
module tb_code_flasher;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       valid;
        logic [3:0] digit;
        logic [2:0] idx;
        logic [6:0] hex;
    } obs_t;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int          n_dig [3] = '{2, 2, 8};
    int          dwell [3] = '{4, 4, 1};
    int          gap   [3] = '{2, 0, 0};
    logic [31:0] codes [3] = '{32'h0000_0028, 32'h0000_0033, 32'hFEDC_BA98};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] start_vec = '0;
    logic [2:0] busy_w, done_w, valid_w;
    logic [3:0] digit_w [3];
    logic [2:0] idx_w   [3];
    logic [6:0] hex_w   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    code_flasher #(.NUM_DIGITS(2), .CODE(32'h0000_0028), .DWELL_CYCLES(4), .GAP_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .start(start_vec[0]), .busy(busy_w[0]), .done(done_w[0]),
        .digit_valid(valid_w[0]), .digit(digit_w[0]), .digit_idx(idx_w[0]), .hex_out(hex_w[0]));

    code_flasher #(.NUM_DIGITS(2), .CODE(32'h0000_0033), .DWELL_CYCLES(4), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .start(start_vec[1]), .busy(busy_w[1]), .done(done_w[1]),
        .digit_valid(valid_w[1]), .digit(digit_w[1]), .digit_idx(idx_w[1]), .hex_out(hex_w[1]));

    code_flasher #(.NUM_DIGITS(8), .CODE(32'hFEDC_BA98), .DWELL_CYCLES(1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .start(start_vec[2]), .busy(busy_w[2]), .done(done_w[2]),
        .digit_valid(valid_w[2]), .digit(digit_w[2]), .digit_idx(idx_w[2]), .hex_out(hex_w[2]));

    function automatic obs_t sample(input int dut);
        obs_t o;
        o.busy  = busy_w[dut];
        o.done  = done_w[dut];
        o.valid = valid_w[dut];
        o.digit = digit_w[dut];
        o.idx   = idx_w[dut];
        o.hex   = hex_w[dut];
        return o;
    endfunction

    function automatic obs_t idleObs();
        obs_t o;
        o = '{busy: 1'b0, done: 1'b0, valid: 1'b0, digit: 4'd0, idx: 3'd0, hex: BLANK};
        return o;
    endfunction

    // Fields printed as busy_done_valid_digit_idx_hex.
    task automatic checkOutput(input string tag, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b_%b_%b_%h_%0d_%b expected %b_%b_%b_%h_%0d_%b", tag,
                     got.busy, got.done, got.valid, got.digit, got.idx, got.hex,
                     exp.busy, exp.done, exp.valid, exp.digit, exp.idx, exp.hex);
        end
    endtask

    // Called at a negedge in IDLE: pulses start, queues the expected trace, then checks every cycle
    // through the trailing IDLE cycle. extra_a/extra_b re-raise start during those cycles.
    task automatic applyStimulus(input int dut, input int extra_a, input int extra_b);
        obs_t exp_q [$];
        obs_t e;
        logic [3:0] dig;
        int n;
        for (int d = n_dig[dut] - 1; d >= 0; d--) begin
            dig = 4'((codes[dut] >> (4 * d)) & 32'hF);
            for (int c = 0; c < dwell[dut]; c++)
                exp_q.push_back('{busy: 1'b1, done: 1'b0, valid: 1'b1, digit: dig, idx: 3'(d), hex: SEG_TBL[dig]});
            if (d > 0)
                for (int c = 0; c < gap[dut]; c++)
                    exp_q.push_back('{busy: 1'b1, done: 1'b0, valid: 1'b0, digit: 4'd0, idx: 3'(d), hex: BLANK});
        end
        exp_q.push_back('{busy: 1'b0, done: 1'b1, valid: 1'b0, digit: 4'd0, idx: 3'd0, hex: BLANK});
        exp_q.push_back(idleObs());
        start_vec[dut] = 1'b1;
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            start_vec[dut] = (n == extra_a) || (n == extra_b);
            e = exp_q.pop_front();
            checkOutput($sformatf("dut%0d cycle%0d", dut, n), sample(dut), e);
        end
        start_vec[dut] = 1'b0;
    endtask

    initial begin
        #1;
        for (int d = 0; d < 3; d++) checkOutput($sformatf("reset dut%0d", d), sample(d), idleObs());
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle after reset", sample(0), idleObs());
        end

        $display("[TB] full sequence, defaults");
        applyStimulus(0, 0, 0);

        $display("[TB] start while busy, then restart from IDLE");
        applyStimulus(0, 3, 11);
        applyStimulus(0, 0, 0);

        $display("[TB] async reset during GAP");
        start_vec[0] = 1'b1;
        @(negedge clk);
        start_vec[0] = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("in gap", sample(0),
                    '{busy: 1'b1, done: 1'b0, valid: 1'b0, digit: 4'd0, idx: 3'd1, hex: BLANK});
        #2 reset = 1'b1;
        #1 checkOutput("async reset", sample(0), idleObs());
        @(negedge clk);
        reset = 1'b0;
        repeat (12) begin
            @(negedge clk);
            checkOutput("no done after reset", sample(0), idleObs());
        end
        applyStimulus(0, 0, 0);

        $display("[TB] no gap, repeated digit 3");
        applyStimulus(1, 0, 0);

        $display("[TB] encoder sweep F..8");
        applyStimulus(2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
